// File: rtl/memreq_queue.sv
// rtl/memreq_queue.sv - CPU request FIFO, command sequencer and refresh timer in front of the RAM controller
//
// Purpose: buffers CPU 64-bit word read/write requests, issues them one at a
// time to the RAM controller, returns read data, and interleaves periodic
// refresh commands between transactions.
//
// Ports:
//   clock, resetin          system clock, asynchronous active-high reset
//   cpu_valid/cpu_ready     request handshake (cpu_ready is combinational)
//   cpu_write, cpu_address,
//   cpu_wdata               request payload
//   cpu_rvalid, cpu_rdata   read return (one-cycle pulse, data held)
//   mc_address, mc_wdata    command payload to controller
//   mc_read, mc_write,
//   mc_refresh              command strobes, held until completion
//   mc_rdata, mc_done_n     controller read data and active-low completion
//   refresh_overrun         sticky: timer expired with a refresh still pending
module memreq_queue #(
   parameter int DEPTH            = 4,
   parameter int REFRESH_INTERVAL = 780
) (
   input  logic        clock,
   input  logic        resetin,
   input  logic        cpu_valid,
   output logic        cpu_ready,
   input  logic        cpu_write,
   input  logic [63:0] cpu_address,
   input  logic [63:0] cpu_wdata,
   output logic        cpu_rvalid,
   output logic [63:0] cpu_rdata,
   output logic [63:0] mc_address,
   output logic        mc_read,
   output logic        mc_write,
   output logic [63:0] mc_wdata,
   input  logic [63:0] mc_rdata,
   input  logic        mc_done_n,
   output logic        mc_refresh,
   output logic        refresh_overrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(REFRESH_INTERVAL);
   localparam logic [AW:0]   FULL         = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TIMER_RELOAD = TW'(REFRESH_INTERVAL - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_REFRESH} state_t;

   // FIFO storage (no reset needed: count_q gates every read of it)
   logic        fifo_write_q [DEPTH];
   logic [63:0] fifo_addr_q  [DEPTH];
   logic [63:0] fifo_wdata_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pending_q, pending_d;
   logic          overrun_q, overrun_d;
   state_t        state_q, state_d;
   logic          mc_read_q, mc_read_d, mc_write_q, mc_write_d, mc_refresh_q, mc_refresh_d;
   logic [63:0]   mc_address_q, mc_address_d, mc_wdata_q, mc_wdata_d;
   logic          rvalid_q, rvalid_d;
   logic [63:0]   rdata_q, rdata_d;

   logic push, pop, expire, refresh_done;

   assign cpu_ready       = (count_q != FULL);
   assign push            = cpu_valid & cpu_ready;
   assign cpu_rvalid      = rvalid_q;
   assign cpu_rdata       = rdata_q;
   assign mc_address      = mc_address_q;
   assign mc_wdata        = mc_wdata_q;
   assign mc_read         = mc_read_q;
   assign mc_write        = mc_write_q;
   assign mc_refresh      = mc_refresh_q;
   assign refresh_overrun = overrun_q;

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_write_q[wr_ptr_q] <= cpu_write;
         fifo_addr_q[wr_ptr_q]  <= cpu_address;
         fifo_wdata_q[wr_ptr_q] <= cpu_wdata;
      end
   end

   // Pointers wrap for free because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      expire  = (timer_q == '0);
      timer_d = expire ? TIMER_RELOAD : timer_q - TW'(1);
   end

   always_comb begin
      state_d      = state_q;
      mc_read_d    = mc_read_q;
      mc_write_d   = mc_write_q;
      mc_refresh_d = mc_refresh_q;
      mc_address_d = mc_address_q;
      mc_wdata_d   = mc_wdata_q;
      rvalid_d     = 1'b0;
      rdata_d      = rdata_q;
      pop          = 1'b0;
      refresh_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               mc_refresh_d = 1'b1;
               state_d      = ST_REFRESH;
            end else if (count_q != '0) begin
               mc_address_d = fifo_addr_q[rd_ptr_q];
               mc_wdata_d   = fifo_wdata_q[rd_ptr_q];
               mc_write_d   = fifo_write_q[rd_ptr_q];
               mc_read_d    = ~fifo_write_q[rd_ptr_q];
               state_d      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!mc_done_n) begin
               mc_read_d  = 1'b0;
               mc_write_d = 1'b0;
               pop        = 1'b1;
               if (mc_read_q) begin
                  rvalid_d = 1'b1;
                  rdata_d  = mc_rdata;
               end
               state_d = ST_IDLE;
            end
         end
         ST_REFRESH: begin
            if (!mc_done_n) begin
               mc_refresh_d = 1'b0;
               refresh_done = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // An expiry coinciding with refresh completion re-arms pending rather
   // than counting as an overrun: the old request is being retired.
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      if (expire) begin
         if (pending_q && !refresh_done) overrun_d = 1'b1;
         pending_d = 1'b1;
      end else if (refresh_done) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge resetin) begin
      if (resetin) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         timer_q      <= TIMER_RELOAD;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         state_q      <= ST_IDLE;
         mc_read_q    <= 1'b0;
         mc_write_q   <= 1'b0;
         mc_refresh_q <= 1'b0;
         mc_address_q <= '0;
         mc_wdata_q   <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         timer_q      <= timer_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         state_q      <= state_d;
         mc_read_q    <= mc_read_d;
         mc_write_q   <= mc_write_d;
         mc_refresh_q <= mc_refresh_d;
         mc_address_q <= mc_address_d;
         mc_wdata_q   <= mc_wdata_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

endmodule

// File: tb/tb_memreq_queue.sv
// tb/tb_memreq_queue.sv - directed self-checking bench for memreq_queue
module tb_memreq_queue;
   localparam int DEPTH = 4;
   localparam int RI    = 40;

   logic        clock = 1'b0;
   logic        resetin = 1'b1;
   logic        cpu_valid = 1'b0;
   logic        cpu_ready;
   logic        cpu_write = 1'b0;
   logic [63:0] cpu_address = '0;
   logic [63:0] cpu_wdata = '0;
   logic        cpu_rvalid;
   logic [63:0] cpu_rdata;
   logic [63:0] mc_address;
   logic        mc_read;
   logic        mc_write;
   logic [63:0] mc_wdata;
   logic [63:0] mc_rdata = '0;
   logic        mc_done_n = 1'b1;
   logic        mc_refresh;
   logic        refresh_overrun;

   int checks = 0;
   int errors = 0;

   memreq_queue #(.DEPTH(DEPTH), .REFRESH_INTERVAL(RI)) dut (
      .clock(clock), .resetin(resetin),
      .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
      .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mc_address(mc_address), .mc_read(mc_read), .mc_write(mc_write),
      .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_done_n(mc_done_n),
      .mc_refresh(mc_refresh), .refresh_overrun(refresh_overrun)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      mc_done_n = 1'b1;
      mc_rdata  = '0;
      resetin   = 1'b1;
      step();
      resetin   = 1'b0;
   endtask

   task automatic push_req(input logic wr, input logic [63:0] addr, input logic [63:0] data);
      cpu_valid   = 1'b1;
      cpu_write   = wr;
      cpu_address = addr;
      cpu_wdata   = data;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_mc_read", mc_read, 0);
      check("rst_mc_write", mc_write, 0);
      check("rst_mc_refresh", mc_refresh, 0);
      check("rst_mc_address", mc_address, 0);
      check("rst_mc_wdata", mc_wdata, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_cpu_rvalid", cpu_rvalid, 0);
      check("rst_overrun", refresh_overrun, 0);
      check("rst_cpu_ready", cpu_ready, 1);

      // Single read
      push_req(1'b0, 64'h10, 64'h0);
      step();
      cpu_valid = 1'b0;
      check("rd_not_yet", mc_read, 0);
      step();
      check("rd_issued", mc_read, 1);
      check("rd_addr", mc_address, 64'h10);
      check("rd_no_write", mc_write, 0);
      step();
      step();
      check("rd_held", mc_read, 1);
      check("rd_no_rvalid_early", cpu_rvalid, 0);
      mc_done_n = 1'b0;
      mc_rdata  = 64'hDEADBEEF;
      step();
      mc_done_n = 1'b1;
      mc_rdata  = 64'h0;
      check("rd_rvalid", cpu_rvalid, 1);
      check("rd_rdata", cpu_rdata, 64'hDEADBEEF);
      check("rd_drop", mc_read, 0);
      step();
      check("rd_rvalid_pulse", cpu_rvalid, 0);
      check("rd_rdata_hold", cpu_rdata, 64'hDEADBEEF);
      check("rd_idle", mc_read, 0);

      // Fill and drain
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_req(1'b1, 64'h100 + 64'(i), 64'hA0 + 64'(i));
         step();
      end
      check("fill_ready_low", cpu_ready, 0);
      push_req(1'b1, 64'h104, 64'hA4);
      step();
      check("fill_held", cpu_ready, 0);
      check("fill_count", 64'(dut.count_q), 4);
      check("fill_w0", mc_write, 1);
      check("fill_w0_addr", mc_address, 64'h100);
      check("fill_w0_data", mc_wdata, 64'hA0);
      mc_done_n = 1'b0;
      step();
      mc_done_n = 1'b1;
      check("fill_ready_after_pop", cpu_ready, 1);
      check("fill_w0_drop", mc_write, 0);
      check("fill_no_rvalid_wr", cpu_rvalid, 0);
      step();
      cpu_valid = 1'b0;
      check("fill_w4_accepted", cpu_ready, 0);
      for (int i = 1; i < 5; i++) begin
         check("drain_write", mc_write, 1);
         check("drain_addr", mc_address, 64'h100 + 64'(i));
         check("drain_data", mc_wdata, 64'hA0 + 64'(i));
         mc_done_n = 1'b0;
         step();
         mc_done_n = 1'b1;
         check("drain_drop", mc_write, 0);
         step();
      end
      check("drain_empty_ready", cpu_ready, 1);
      check("drain_empty_idle", mc_write, 0);
      check("drain_empty_count", 64'(dut.count_q), 0);

      // Simultaneous push/pop across pointer wrap
      do_reset();
      push_req(1'b1, 64'h200, 64'hB0);
      step();
      push_req(1'b1, 64'h201, 64'hB1);
      step();
      cpu_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check("pp_write", mc_write, 1);
         check("pp_addr", mc_address, 64'h200 + 64'(k));
         check("pp_data", mc_wdata, 64'hB0 + 64'(k));
         push_req(1'b1, 64'h200 + 64'(k + 2), 64'hB0 + 64'(k + 2));
         mc_done_n = 1'b0;
         step();
         mc_done_n = 1'b1;
         cpu_valid = 1'b0;
         check("pp_count", 64'(dut.count_q), 2);
         step();
      end

      // Refresh priority (interval expires while a write is outstanding)
      do_reset();
      push_req(1'b1, 64'h400, 64'hC0);
      step();
      push_req(1'b1, 64'h401, 64'hC1);
      step();
      cpu_valid = 1'b0;
      for (int i = 0; i < RI - 3; i++) step();
      check("ref_pending_before", 64'(dut.pending_q), 0);
      step();
      check("ref_pending_set", 64'(dut.pending_q), 1);
      check("ref_no_preempt_wr", mc_write, 1);
      check("ref_no_preempt_ref", mc_refresh, 0);
      mc_done_n = 1'b0;
      step();
      mc_done_n = 1'b1;
      check("ref_wr_done", mc_write, 0);
      check("ref_not_yet", mc_refresh, 0);
      step();
      check("ref_issued", mc_refresh, 1);
      check("ref_before_next_wr", mc_write, 0);
      step();
      step();
      check("ref_held", mc_refresh, 1);
      mc_done_n = 1'b0;
      step();
      mc_done_n = 1'b1;
      check("ref_cleared", mc_refresh, 0);
      check("ref_pending_clear", 64'(dut.pending_q), 0);
      step();
      check("ref_next_wr", mc_write, 1);
      check("ref_next_addr", mc_address, 64'h401);
      check("ref_next_data", mc_wdata, 64'hC1);

      // Overrun: refresh never completes
      do_reset();
      for (int i = 0; i < RI - 1; i++) step();
      check("ovr_pending_before", 64'(dut.pending_q), 0);
      step();
      check("ovr_pending_set", 64'(dut.pending_q), 1);
      step();
      check("ovr_ref_issued", mc_refresh, 1);
      for (int i = 0; i < RI - 2; i++) step();
      check("ovr_not_yet", refresh_overrun, 0);
      step();
      check("ovr_set", refresh_overrun, 1);
      for (int i = 0; i < 5; i++) step();
      check("ovr_sticky", refresh_overrun, 1);
      check("ovr_ref_held", mc_refresh, 1);
      mc_done_n = 1'b0;
      step();
      mc_done_n = 1'b1;
      check("ovr_ref_done", mc_refresh, 0);
      check("ovr_sticky_after", refresh_overrun, 1);

      // Reset mid-read
      do_reset();
      check("rstmid_ovr_cleared", refresh_overrun, 0);
      push_req(1'b0, 64'h300, 64'h0);
      step();
      push_req(1'b0, 64'h308, 64'h0);
      step();
      cpu_valid = 1'b0;
      check("rstmid_read", mc_read, 1);
      check("rstmid_addr", mc_address, 64'h300);
      mc_rdata  = 64'h55;
      resetin   = 1'b1;
      #1;
      check("rstmid_async_read", mc_read, 0);
      check("rstmid_async_addr", mc_address, 0);
      check("rstmid_async_ready", cpu_ready, 1);
      check("rstmid_async_count", 64'(dut.count_q), 0);
      mc_done_n = 1'b0;
      step();
      resetin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rstmid_no_rvalid", cpu_rvalid, 0);
         check("rstmid_no_read", mc_read, 0);
      end
      check("rstmid_rdata", cpu_rdata, 0);
      mc_done_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
